// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
// IMEM_LOADER_CKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

  localparam int BYTE_W  = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_HI  = 3'd1,
    S_HDR_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKSUM   = 3'd5,
`endif
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

endpackage

// File: rtl/imem_ld_cksum.sv
// Running XOR of the instruction bytes of one load; only built with
// IMEM_LOADER_CKSUM_EN defined.
module imem_ld_cksum
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sum <= '0;
    else if (clear) sum <= '0;
    else if (en)    sum <= sum ^ data;
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> 16-bit big-endian words -> imem write port,
// holding the CPU in reset until a clean load. Option: IMEM_LOADER_CKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [BYTE_W-1:0]  in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  // A full memory is 2**ADDR_W words, so the limit needs one bit above the count.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state;
  logic [BYTE_W-1:0] count_hi;
  logic [BYTE_W-1:0] instr_hi;
  logic [15:0]       count;
  logic [16:0]       idx;

  logic              accept;
  logic [15:0]       hdr_count;
  logic [16:0]       idx_next;
  logic              last_word;
  logic              restart;

  assign accept    = in_valid && in_ready;
  assign hdr_count = {count_hi, in_data};
  assign idx_next  = idx + 17'd1;
  assign last_word = (idx_next == {1'b0, count});
  assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

`ifdef IMEM_LOADER_CKSUM_EN
  logic [BYTE_W-1:0] cksum;

  imem_ld_cksum u_cksum (
    .clk   (clk),
    .rst_n (rst),
    .clear (restart),
    .en    (accept && (state == S_DATA_HI || state == S_DATA_LO)),
    .data  (in_data),
    .sum   (cksum)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      count_hi  <= '0;
      instr_hi  <= '0;
      count     <= '0;
      idx       <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every branch sees the
      // pre-edge state; mem_we defaults low here so it can only pulse.
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_HDR_HI;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        S_HDR_HI: begin
          if (accept) begin
            count_hi <= in_data;
            state    <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (accept) begin
            count <= hdr_count;
            idx   <= '0;
            if ({1'b0, hdr_count} > DEPTH) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else if (hdr_count == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state    <= S_CKSUM;
`else
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            instr_hi <= in_data;
            state    <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + idx[ADDR_W-1:0];
            mem_wdata <= {instr_hi, in_data};
            idx       <= idx_next;
            if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state    <= S_CKSUM;
`else
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == cksum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: three instances (base 0, base FE, 4-bit
// address) share one byte stream; checksum cases under IMEM_LOADER_CKSUM_EN.
module tb_imem_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        rdy  [3];
  logic        we   [3];
  logic        hold [3];
  logic        dn   [3];
  logic        er   [3];
  logic [15:0] wd   [3];
  logic [7:0]  a0, a1;
  logic [3:0]  a2;

  wr_t wq0[$], wq1[$], wq2[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) u0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .mem_we(we[0]), .mem_addr(a0), .mem_wdata(wd[0]),
    .cpu_hold(hold[0]), .done(dn[0]), .err(er[0]));

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .mem_we(we[1]), .mem_addr(a1), .mem_wdata(wd[1]),
    .cpu_hold(hold[1]), .done(dn[1]), .err(er[1]));

  imem_loader #(.ADDR_W(4), .BASE_ADDR(4'h0)) u2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[2]), .mem_we(we[2]), .mem_addr(a2), .mem_wdata(wd[2]),
    .cpu_hold(hold[2]), .done(dn[2]), .err(er[2]));

  // Every cycle with mem_we high logs one write; a stretched pulse shows up
  // as an extra entry.
  always @(negedge clk) begin
    if (we[0]) wq0.push_back({a0, wd[0]});
    if (we[1]) wq1.push_back({a1, wd[1]});
    if (we[2]) wq2.push_back({4'h0, a2, wd[2]});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input wr_t q[$], input int n,
                          input logic [7:0] ea[3], input logic [15:0] ed[3]);
    check({tag, "_count"}, q.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), q[i].addr, ea[i]);
      check($sformatf("%s_data%0d", tag, i), q[i].data, ed[i]);
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap, input int sel);
    bit ok = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rdy[sel]) ok = 1'b1;
      @(negedge clk);
    end
    check("accept_in_time", ok, 1);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap, input int sel);
    foreach (s[i]) send_byte(s[i], gap, sel);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    #1;
    wq0.delete();
    wq1.delete();
    wq2.delete();
  endtask

  logic [7:0] s[$];

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);

    check("rst_in_ready", rdy[0], 0);
    check("rst_mem_we", we[0], 0);
    check("rst_mem_addr", a0, 8'h00);
    check("rst_mem_addr_base", a1, 8'hFE);
    check("rst_mem_wdata", wd[0], 16'h0000);
    check("rst_cpu_hold", hold[0], 1);
    check("rst_done", dn[0], 0);
    check("rst_err", er[0], 0);

    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", rdy[0], 0);

    // Three words back-to-back
    pulse_start();
    check("ready_after_start", rdy[0], 1);
    s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
`ifdef IMEM_LOADER_CKSUM_EN
    s.push_back(8'h41);
`endif
    send_stream(s, 0, 0);
    @(negedge clk);
    check("b2b_done", dn[0], 1);
    check("b2b_cpu_hold", hold[0], 0);
    check("b2b_in_ready", rdy[0], 0);
    check("b2b_mem_we_low", we[0], 0);
    #1;
    check_wr("b2b", wq0, 3, '{8'h00, 8'h01, 8'h02}, '{16'h1234, 16'hABCD, 16'h0001});
    check_wr("wrap", wq1, 3, '{8'hFE, 8'hFF, 8'h00}, '{16'h1234, 16'hABCD, 16'h0001});
    check("b2b_addr_hold", a0, 8'h02);

    // Restart from DONE with gaps between bytes
    clear_logs();
    @(negedge clk);
    pulse_start();
    check("restart_done_clr", dn[0], 0);
    check("restart_cpu_hold", hold[0], 1);
    send_stream(s, 3, 0);
    repeat (4) @(negedge clk);
    check("gap_done", dn[0], 1);
    #1;
    check_wr("gap", wq0, 3, '{8'h00, 8'h01, 8'h02}, '{16'h1234, 16'hABCD, 16'h0001});

    // Count out of range on the 16-word instance
    do_reset();
    clear_logs();
    @(negedge clk);
    pulse_start();
    send_byte(8'h00, 0, 2);
    send_byte(8'h11, 0, 2);
    in_valid = 1'b0;
    check("oor_err", er[2], 1);
    check("oor_in_ready", rdy[2], 0);
    check("oor_cpu_hold", hold[2], 1);
    repeat (5) @(negedge clk);
    check("oor_cpu_hold_stays", hold[2], 1);
    check("oor_done", dn[2], 0);
    #1;
    check("oor_no_writes", wq2.size(), 0);
    @(negedge clk);
    pulse_start();
    check("oor_recover_err", er[2], 0);
    s = '{8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CKSUM_EN
    s.push_back(8'h51);
`endif
    send_stream(s, 0, 2);
    @(negedge clk);
    check("oor_recover_done", dn[2], 1);
    #1;
    check_wr("oor_recover", wq2, 1, '{8'h00, 8'h00, 8'h00}, '{16'hBEEF, 16'h0000, 16'h0000});

    // Reset after the second data byte
    do_reset();
    pulse_start();
    send_stream('{8'h00, 8'h03, 8'h12, 8'h34}, 0, 0);
    check("pre_rst_mem_we", we[0], 1);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", rdy[0], 0);
    check("mid_rst_mem_we", we[0], 0);
    check("mid_rst_mem_addr", a0, 8'h00);
    check("mid_rst_mem_wdata", wd[0], 16'h0000);
    check("mid_rst_cpu_hold", hold[0], 1);
    check("mid_rst_done", dn[0], 0);
    check("mid_rst_err", er[0], 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // start during DATA_LO is ignored
    pulse_start();
    send_stream('{8'h00, 8'h01, 8'h12}, 0, 0);
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_start_ready", rdy[0], 1);
    s = '{8'h34};
`ifdef IMEM_LOADER_CKSUM_EN
    s.push_back(8'h26);
`endif
    send_stream(s, 0, 0);
    @(negedge clk);
    check("ign_start_done", dn[0], 1);
    #1;
    check_wr("ign_start", wq0, 1, '{8'h00, 8'h00, 8'h00}, '{16'h1234, 16'h0000, 16'h0000});

`ifdef IMEM_LOADER_CKSUM_EN
    // Checksum match and mismatch
    do_reset();
    pulse_start();
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, 0, 0);
    @(negedge clk);
    check("ck_ok_done", dn[0], 1);
    check("ck_ok_hold", hold[0], 0);
    pulse_start();
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41}, 0, 0);
    @(negedge clk);
    check("ck_bad_err", er[0], 1);
    check("ck_bad_done", dn[0], 0);
    check("ck_bad_hold", hold[0], 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
